// File: rtl/audio_pkg.sv
// Shared audio sample types for the microphone and loudness stages.
// Pure type/constant package; no logic, no latency, no flow control.
package audio_pkg;
  localparam int SAMPLE_W = 18;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [SAMPLE_W-1:0] mag_t;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} channel_t;
endpackage

// File: rtl/abs_sat.sv
// Saturating absolute value of a signed sample; the most negative code clamps to max positive.
// Purely combinational, zero latency, no backpressure.
module abs_sat
  import audio_pkg::*;
(
  input  sample_t sample,
  output mag_t    mag
);

  localparam sample_t MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam mag_t    MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  always_comb begin
    if (sample == MOST_NEG) begin
      mag = MOST_POS;
    end else if (sample[SAMPLE_W-1]) begin
      mag = mag_t'(-sample);
    end else begin
      mag = mag_t'(sample);
    end
  end

endmodule

// File: rtl/loudness_meter.sv
// Windowed mean/peak absolute amplitude meter with a held loudness flag.
// Results 1 cycle after the window-closing strobe; strobe-driven input, no backpressure.
module loudness_meter
  import audio_pkg::*;
#(
  parameter int           WINDOW_LOG2  = 10,
  parameter logic [17:0]  THRESHOLD    = 18'd4096,
  parameter int           HOLD_WINDOWS = 4,
  parameter logic         CHANNEL      = 1'b0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  sample_t             sample_in,
  input  logic                sample_valid_in,
  input  logic                sample_channel_in,
  output mag_t                level_out,
  output mag_t                peak_out,
  output logic                level_valid_out,
  output logic                loud_out
);

  localparam int ACC_W  = SAMPLE_W + WINDOW_LOG2;
  localparam int HOLD_W = ($clog2(HOLD_WINDOWS + 1) < 1) ? 1 : $clog2(HOLD_WINDOWS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_WINDOWS);

  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_sum;
  mag_t                   peak;
  mag_t                   peak_next;
  mag_t                   mag;
  mag_t                   level_next;
  logic [WINDOW_LOG2-1:0] cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [HOLD_W-1:0]      hold_next;
  logic                   accept;
  logic                   window_done;

  abs_sat u_abs_sat (
    .sample (sample_in),
    .mag    (mag)
  );

  assign accept      = sample_valid_in && (sample_channel_in == CHANNEL);
  assign window_done = accept && (cnt == {WINDOW_LOG2{1'b1}});
  assign loud_out    = (hold_cnt != '0);

  // The accumulator is wide enough for a full window of max-magnitude samples.
  always_comb begin
    acc_sum    = acc + ACC_W'(mag);
    peak_next  = (mag > peak) ? mag : peak;
    level_next = mag_t'(acc_sum >> WINDOW_LOG2);
    hold_next  = hold_cnt;
    if (level_next >= THRESHOLD) begin
      hold_next = HOLD_LOAD;
    end else if (hold_cnt != '0) begin
      hold_next = hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc             <= '0;
      peak            <= '0;
      cnt             <= '0;
      hold_cnt        <= '0;
      level_out       <= '0;
      peak_out        <= '0;
      level_valid_out <= 1'b0;
    end else begin
      level_valid_out <= 1'b0;
      if (accept) begin
        cnt <= cnt + WINDOW_LOG2'(1);
        if (window_done) begin
          level_out       <= level_next;
          peak_out        <= peak_next;
          level_valid_out <= 1'b1;
          hold_cnt        <= hold_next;
          acc             <= '0;
          peak            <= '0;
        end else begin
          acc  <= acc_sum;
          peak <= peak_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_loudness_meter.sv
// Self-checking bench for loudness_meter: vector table, reset/hold sequences, random traffic.
module tb_loudness_meter;
  import audio_pkg::*;

  localparam int WL   = 2;
  localparam int NWIN = 1 << WL;
  localparam int THR  = 1000;
  localparam int HOLD = 2;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  sample_t s_in = '0;
  logic    s_vld = 1'b0;
  logic    s_ch = 1'b0;
  mag_t    level, peak;
  logic    lvl_vld, loud;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_win[$];
  int m_level = 0, m_peak = 0, m_hold = 0;
  bit m_vld = 0;

  always #5 clk = ~clk;

  loudness_meter #(
    .WINDOW_LOG2  (WL),
    .THRESHOLD    (18'(THR)),
    .HOLD_WINDOWS (HOLD),
    .CHANNEL      (1'b0)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .sample_in         (s_in),
    .sample_valid_in   (s_vld),
    .sample_channel_in (s_ch),
    .level_out         (level),
    .peak_out          (peak),
    .level_valid_out   (lvl_vld),
    .loud_out          (loud)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_abs(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > 131071) ? 131071 : a;
  endfunction

  // Model: mean/peak over each group of NWIN accepted samples, hold counter per close.
  task automatic model_step(input bit r, input bit v, input bit ch, input int x);
    int sum, pk;
    m_vld = 0;
    if (r) begin
      m_win.delete();
      m_level = 0; m_peak = 0; m_hold = 0;
    end else if (v && ch == 1'b0) begin
      m_win.push_back(sat_abs(x));
      if (m_win.size() == NWIN) begin
        sum = 0; pk = 0;
        foreach (m_win[i]) begin
          sum += m_win[i];
          if (m_win[i] > pk) pk = m_win[i];
        end
        m_level = sum / NWIN;
        m_peak  = pk;
        m_vld   = 1;
        if (m_level >= THR) m_hold = HOLD;
        else if (m_hold > 0) m_hold--;
        m_win.delete();
      end
    end
  endtask

  // Drive one cycle of inputs, then check all outputs against the model.
  task automatic step(input bit r, input bit v, input bit ch, input int x);
    rst = r; s_vld = v; s_ch = ch; s_in = sample_t'(x);
    @(posedge clk);
    #1;
    model_step(r, v, ch, x);
    chk("level_valid", int'(lvl_vld), int'(m_vld));
    chk("level", int'(level), m_level);
    chk("peak", int'(peak), m_peak);
    chk("loud", int'(loud), int'(m_hold != 0));
    rst = 1'b0; s_vld = 1'b0;
  endtask

  typedef struct {
    int  s[4];
    bit  interleave;
    int  exp_level;
    int  exp_peak;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{s: '{100, -200, 300, -400},              interleave: 0, exp_level: 250,    exp_peak: 400};
    vecs[1] = '{s: '{-131072, -131072, -131072, -131072}, interleave: 0, exp_level: 131071, exp_peak: 131071};
    vecs[2] = '{s: '{0, 0, 0, 0},                         interleave: 1, exp_level: 0,      exp_peak: 0};
    vecs[3] = '{s: '{7, -7, 8, 0},                        interleave: 0, exp_level: 5,      exp_peak: 8};
    vecs[4] = '{s: '{131071, -131071, 131071, -131071},   interleave: 1, exp_level: 131071, exp_peak: 131071};
    vecs[5] = '{s: '{-1, 1, -1, 2},                       interleave: 0, exp_level: 1,      exp_peak: 2};

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_level", int'(level), 0);
    chk("reset_loud", int'(loud), 0);

    // Table-driven windows
    foreach (vecs[k]) begin
      for (int i = 0; i < 4; i++) begin
        if (vecs[k].interleave) step(0, 1, 1, 50000);
        step(0, 1, 0, vecs[k].s[i]);
      end
      chk($sformatf("tbl%0d_vld", k), int'(lvl_vld), 1);
      chk($sformatf("tbl%0d_level", k), int'(level), vecs[k].exp_level);
      chk($sformatf("tbl%0d_peak", k), int'(peak), vecs[k].exp_peak);
      step(0, 0, 0, 0);
      chk($sformatf("tbl%0d_vld_once", k), int'(lvl_vld), 0);
      chk($sformatf("tbl%0d_hold_level", k), int'(level), vecs[k].exp_level);
    end

    // Mid-window reset discards partial window; strobe during reset is ignored
    step(0, 1, 0, 500);
    step(0, 1, 0, 500);
    step(1, 1, 0, 9999);
    chk("rst_level", int'(level), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_loud", int'(loud), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 10);
    chk("post_rst_vld", int'(lvl_vld), 1);
    chk("post_rst_level", int'(level), 10);

    // Hold: loud window then quiet windows
    for (int i = 0; i < 4; i++) step(0, 1, 0, (i % 2) ? -2000 : 2000);
    chk("hold_close1", int'(loud), 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("hold_close2", int'(loud), 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("hold_close3", int'(loud), 0);

    // Back-to-back strobes across several windows
    begin
      int closes = 0;
      for (int i = 0; i < 4 * NWIN; i++) begin
        step(0, 1, 0, $urandom_range(3000, 0) - 1000);
        if (lvl_vld) closes++;
      end
      chk("b2b_closes", closes, 4);
    end

    // Random traffic, mixed channels and extremes
    for (int i = 0; i < 600; i++) begin
      int x;
      case ($urandom_range(7, 0))
        0: x = -131072;
        1: x = 131071;
        2: x = $urandom_range(4000, 0) - 2000;
        default: x = $urandom_range(262143, 0) - 131072;
      endcase
      step(($urandom_range(99, 0) == 0), ($urandom_range(3, 0) != 0), $urandom_range(1, 0), x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/loudness_meter.md
LOUDNESS_METER -- requirements
Module: loudness_meter

Interface
REQ-001 SHALL expose parameter WINDOW_LOG2, default 10: window length is 2^WINDOW_LOG2 accepted samples.
REQ-002 SHALL expose parameter THRESHOLD, default 18'd4096: level at or above which a window counts as loud.
REQ-003 SHALL expose parameter HOLD_WINDOWS, default 4: windows loud_out is held after the last loud window.
REQ-004 SHALL expose parameter CHANNEL, default 1'b0: the channel accepted (0 = left/ws low, 1 = right).
REQ-005 clk_in  input  1  system clock (100 MHz); the single clock domain.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 sample_in  input  18  signed two's-complement microphone sample from the microphones stage.
REQ-008 sample_valid_in  input  1  one-cycle strobe; sample_in and sample_channel_in are valid this cycle.
REQ-009 sample_channel_in  input  1  channel tag of the strobed sample.
REQ-010 level_out  output  18  unsigned mean absolute amplitude of the last completed window.
REQ-011 peak_out  output  18  unsigned maximum absolute amplitude of the last completed window.
REQ-012 level_valid_out  output  1  one-cycle strobe: level_out and peak_out updated this cycle.
REQ-013 loud_out  output  1  level-qualified loudness flag with hold.

Function
REQ-014 A sample SHALL be accepted only when sample_valid_in=1 and sample_channel_in=CHANNEL; all other cycles leave state unchanged.
REQ-015 Absolute value SHALL saturate: -131072 maps to 131071; all other values map to |x|.
REQ-016 Accumulator SHALL be 18+WINDOW_LOG2 bits wide, unsigned, and never overflow.
REQ-017 Sample counter SHALL be WINDOW_LOG2 bits, incrementing per accepted sample and wrapping from 2^WINDOW_LOG2-1 to 0.
REQ-018 On the accepted sample with counter = 2^WINDOW_LOG2-1, next cycle: level_out = (acc + abs) >> WINDOW_LOG2 (truncating), peak_out = max(running peak, abs), level_valid_out = 1.
REQ-019 Also on that sample, the accumulator and running peak SHALL clear to 0 so the next accepted sample begins a fresh window; no sample is dropped or double-counted.
REQ-020 level_valid_out SHALL be high for exactly one cycle per completed window; latency from the closing sample strobe is 1 cycle.
REQ-021 level_out and peak_out SHALL hold their values between strobes.
REQ-022 Hold counter, 0..HOLD_WINDOWS: at each window close, a level >= THRESHOLD loads HOLD_WINDOWS; otherwise, if nonzero, it decrements.
REQ-023 loud_out SHALL equal (hold counter != 0), updated in the same cycle as level_valid_out.
REQ-024 With HOLD_WINDOWS=1, loud_out SHALL track exactly the most recent window's comparison.
REQ-025 A sample strobe arriving in the cycle level_valid_out is high SHALL be accepted normally as part of the new window.

Reset
REQ-026 While rst_in=1 at a clock edge, SHALL clear the accumulator, running peak, sample counter and hold counter, and set level_out=0, peak_out=0, level_valid_out=0, loud_out=0.
REQ-027 Reset mid-window SHALL discard the partial window; the first accepted sample after reset is sample 0 of a new window.
REQ-028 A sample strobed in the same cycle as rst_in=1 SHALL be ignored.

Structure
REQ-029 Sample width (18) and the sample/channel typedefs SHALL live in shared package audio_pkg, also used by the microphones stage.
REQ-030 Saturating absolute value SHALL be a combinational sub-module abs_sat; the windowing, peak and hold logic stays in loudness_meter.

Verification
REQ-031 WINDOW_LOG2=2; feed 4 left samples 100, -200, 300, -400 -> one cycle after the 4th strobe: level_valid_out=1, level_out=250, peak_out=400.
REQ-032 Feed -131072 four times (WINDOW_LOG2=2) -> level_out=131071, peak_out=131071, no accumulator overflow.
REQ-033 Interleave right-channel strobes carrying 50000 with left-channel zeros -> level_out=0; right samples ignored.
REQ-034 THRESHOLD=1000, HOLD_WINDOWS=2; one window of level 2000, then quiet windows -> loud_out high for 2 window closes, then low at the 3rd close.
REQ-035 Assert rst_in after 2 of 4 samples, then feed 4 samples of 10 -> first strobe reports level_out=10; all outputs were 0 during reset.
REQ-036 Back-to-back strobes every cycle across a window boundary -> exactly one level_valid_out per 2^WINDOW_LOG2 samples; totals match a reference model.
